// File: rtl/koa_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// koa_mult_arbiter_if
//
// Purpose:
//   Bundles the requester and multiplier signals of koa_mult_arbiter so the
//   arbiter and its environment connect through one port.
//
// Signal summary (names are from the arbiter's point of view):
//   req_i          [1:0]     per-requester request level
//   Data_A0_i      [SW-1:0]  requester 0 operand A
//   Data_B0_i      [SW-1:0]  requester 0 operand B
//   Data_A1_i      [SW-1:0]  requester 1 operand A
//   Data_B1_i      [SW-1:0]  requester 1 operand B
//   gnt_o          [1:0]     combinational one-hot grant
//   mul_A_o        [SW-1:0]  registered operand A to the multiplier
//   mul_B_o        [SW-1:0]  registered operand B to the multiplier
//   mul_valid_o              registered new-job strobe to the multiplier
//   mul_result_i   [2*SW-1:0] product returned by the multiplier
//   sgf_result_o   [2*SW-1:0] registered product for the issuer
//   done_o         [1:0]     registered one-hot result-valid pulse
//   inflight_o     [4:0]     issued jobs whose done has not yet been produced
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (both requesters plus the shared multiplier)
// -----------------------------------------------------------------------------
interface koa_mult_arbiter_if #(
  parameter int SW = 54
);

  logic [1:0]      req_i;
  logic [SW-1:0]   Data_A0_i;
  logic [SW-1:0]   Data_B0_i;
  logic [SW-1:0]   Data_A1_i;
  logic [SW-1:0]   Data_B1_i;
  logic [1:0]      gnt_o;
  logic [SW-1:0]   mul_A_o;
  logic [SW-1:0]   mul_B_o;
  logic            mul_valid_o;
  logic [2*SW-1:0] mul_result_i;
  logic [2*SW-1:0] sgf_result_o;
  logic [1:0]      done_o;
  logic [4:0]      inflight_o;

  modport slave (
    input  req_i,
    input  Data_A0_i,
    input  Data_B0_i,
    input  Data_A1_i,
    input  Data_B1_i,
    input  mul_result_i,
    output gnt_o,
    output mul_A_o,
    output mul_B_o,
    output mul_valid_o,
    output sgf_result_o,
    output done_o,
    output inflight_o
  );

  modport master (
    output req_i,
    output Data_A0_i,
    output Data_B0_i,
    output Data_A1_i,
    output Data_B1_i,
    output mul_result_i,
    input  gnt_o,
    input  mul_A_o,
    input  mul_B_o,
    input  mul_valid_o,
    input  sgf_result_o,
    input  done_o,
    input  inflight_o
  );

endinterface

// File: rtl/koa_mult_arbiter.sv
// -----------------------------------------------------------------------------
// koa_mult_arbiter
//
// Purpose:
//   Shares one fixed-latency Karatsuba significand multiplier between two
//   requesters (port 0: FPU multiply path, port 1: divide/sqrt iteration).
//   Requests are arbitrated round-robin, one job is launched per cycle from
//   registered operands, and a tag shift register running alongside the
//   multiplier routes every product back to the requester that issued it
//   with a single-cycle done pulse.
//
// Parameters:
//   SW  - significand width (54 double, 24 single). Must match the SW of the
//         connected koa_mult_arbiter_if instance.
//   LAT - multiplier latency from mul_valid_o to mul_result_i, 0..15.
//         0 means the multiplier is purely combinational.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - koa_mult_arbiter_if.slave (requests, operands, grant, multiplier
//         launch/return, results, done pulses, in-flight count)
//
// Timing:
//   grant in cycle T -> mul_valid_o in T+1 -> product valid in T+1+LAT
//   -> done_o / sgf_result_o in T+LAT+2. Results return in issue order.
// -----------------------------------------------------------------------------
module koa_mult_arbiter #(
  parameter int SW  = 54,
  parameter int LAT = 2
) (
  input logic              clk,
  input logic              rst,
  koa_mult_arbiter_if.slave bus
);

  // Index of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic       rr_last;

  // Combinational grant and its decoded forms.
  logic [1:0] gnt;
  logic       issue;
  logic       gnt_id;

  // Requester index of the job currently presented on mul_A_o/mul_B_o.
  logic       launch_id;

  // Tag at the output of the tag pipe, aligned with a valid mul_result_i.
  logic       ret_valid;
  logic       ret_id;

  logic [4:0] inflight_q;

  // Round-robin grant. A lone request is granted directly; on a tie the
  // requester that did not win last time is chosen. Reset suppresses any
  // grant so nothing can be captured while the block is being cleared.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (bus.req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign issue     = gnt[0] | gnt[1];
  assign gnt_id    = gnt[1];
  assign bus.gnt_o = gnt;

  // Operand launch register. Operands are only loaded on a grant so the
  // multiplier inputs stay quiet while nobody is requesting; mul_valid_o
  // marks the cycles in which they form a new job. The round-robin pointer
  // and the launch id follow the same grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mul_A_o     <= '0;
      bus.mul_B_o     <= '0;
      bus.mul_valid_o <= 1'b0;
      launch_id       <= 1'b0;
      rr_last         <= 1'b1;
    end else begin
      bus.mul_valid_o <= issue;
      if (issue) begin
        bus.mul_A_o <= gnt_id ? bus.Data_A1_i : bus.Data_A0_i;
        bus.mul_B_o <= gnt_id ? bus.Data_B1_i : bus.Data_B0_i;
        launch_id   <= gnt_id;
        rr_last     <= gnt_id;
      end
    end
  end

  // Tag pipe. It mirrors the multiplier's latency so that the tag leaving
  // the last stage describes the product currently on mul_result_i. With a
  // combinational multiplier the launch register itself is the tag. Reset
  // empties the pipe, which is what discards jobs issued before a reset
  // even though the multiplier may still present their data later.
  generate
    if (LAT == 0) begin : g_comb_tag
      assign ret_valid = bus.mul_valid_o;
      assign ret_id    = launch_id;
    end else begin : g_pipe_tag
      logic [LAT-1:0] tag_valid;
      logic [LAT-1:0] tag_id;

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid <= '0;
          tag_id    <= '0;
        end else begin
          tag_valid[0] <= bus.mul_valid_o;
          tag_id[0]    <= launch_id;
          for (int i = 1; i < LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
          end
        end
      end

      assign ret_valid = tag_valid[LAT-1];
      assign ret_id    = tag_id[LAT-1];
    end
  endgenerate

  // Retire stage. A valid tag captures the product and raises the done bit
  // of its issuer for one cycle; otherwise the last product is held and
  // done_o returns to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sgf_result_o <= '0;
      bus.done_o       <= 2'b00;
    end else if (ret_valid) begin
      bus.sgf_result_o <= bus.mul_result_i;
      bus.done_o       <= ret_id ? 2'b10 : 2'b01;
    end else begin
      bus.done_o       <= 2'b00;
    end
  end

  // In-flight counter. A job counts from its launch until its done pulse;
  // an issue and a retire on the same edge cancel. The count is bounded by
  // the pipeline depth, so it never exceeds LAT+2 and cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({issue, ret_valid})
        2'b10:   inflight_q <= inflight_q + 5'd1;
        2'b01:   inflight_q <= inflight_q - 5'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.inflight_o = inflight_q;

endmodule

// File: tb/tb_koa_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_koa_mult_arbiter
//
// Purpose:
//   Self-checking bench for koa_mult_arbiter. A LAT=2 instance is driven
//   through reset, single issue, idle hold, reset mid-flight, round-robin
//   contention and back-to-back traffic; a LAT=0 instance covers the
//   combinational multiplier build. Expected products, done ids and done
//   cycles are queued when a grant is expected and popped when done_o fires.
// -----------------------------------------------------------------------------
module tb_koa_mult_arbiter;

  localparam int SW  = 54;
  localparam int LAT = 2;
  localparam int PW  = 2 * SW;

  typedef struct {
    logic [1:0]    done;
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;

  koa_mult_arbiter_if #(.SW(SW)) bus ();
  koa_mult_arbiter_if #(.SW(SW)) bus0 ();

  koa_mult_arbiter #(.SW(SW), .LAT(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  koa_mult_arbiter #(.SW(SW), .LAT(0)) u_dut_l0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier models: two-stage pipelined for the LAT=2 instance,
  // purely combinational for the LAT=0 instance
  logic [PW-1:0] mp1;
  logic [PW-1:0] mp2;

  always @(posedge clk) begin
    mp1 <= PW'(bus.mul_A_o) * PW'(bus.mul_B_o);
    mp2 <= mp1;
  end

  assign bus.mul_result_i  = mp2;
  assign bus0.mul_result_i = PW'(bus0.mul_A_o) * PW'(bus0.mul_B_o);

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests at the negedge, check the grant, and queue
  // the expected result of whichever requester should be granted
  task automatic applyStimulus(input logic [1:0] req, input logic [SW-1:0] a0, input logic [SW-1:0] b0,
                               input logic [SW-1:0] a1, input logic [SW-1:0] b1, input logic [1:0] exp_gnt);
    logic [PW-1:0] p;
    @(negedge clk);
    bus.req_i     = req;
    bus.Data_A0_i = a0;
    bus.Data_B0_i = b0;
    bus.Data_A1_i = a1;
    bus.Data_B1_i = b1;
    #1;
    checkOutput("gnt", bus.gnt_o, exp_gnt);
    if (exp_gnt == 2'b01) begin
      p = PW'(a0) * PW'(b0);
      sb.push_back('{done: 2'b01, prod: p, cyc: cyc + LAT + 2});
    end else if (exp_gnt == 2'b10) begin
      p = PW'(a1) * PW'(b1);
      sb.push_back('{done: 2'b10, prod: p, cyc: cyc + LAT + 2});
    end
  endtask

  // Drop requests and wait (bounded) for every queued result to come back
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.req_i = 2'b00;
    #2;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Result monitor: every done pulse must match the oldest queued job in
  // id, product and cycle
  always @(negedge clk) begin
    if (bus.done_o !== 2'b00 && !$isunknown(bus.done_o)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", bus.done_o, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("done_id", bus.done_o, mon_e.done);
        checkOutput("product", bus.sgf_result_o, mon_e.prod);
        checkOutput("latency", cyc, mon_e.cyc);
      end
    end
  end

  // Run-time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    logic [SW-1:0] big;
    logic [SW-1:0] m;
    logic [PW-1:0] mm;

    rst            = 1'b1;
    bus.req_i      = 2'b00;
    bus.Data_A0_i  = '0;
    bus.Data_B0_i  = '0;
    bus.Data_A1_i  = '0;
    bus.Data_B1_i  = '0;
    bus0.req_i     = 2'b00;
    bus0.Data_A0_i = '0;
    bus0.Data_B0_i = '0;
    bus0.Data_A1_i = '0;
    bus0.Data_B1_i = '0;

    // Reset: grant forced low even with both requesting, outputs cleared
    repeat (2) @(negedge clk);
    bus.req_i  = 2'b11;
    bus0.req_i = 2'b11;
    #1;
    checkOutput("rst_gnt", bus.gnt_o, 2'b00);
    checkOutput("rst_gnt_l0", bus0.gnt_o, 2'b00);
    @(negedge clk);
    checkOutput("rst_mul_A", bus.mul_A_o, 0);
    checkOutput("rst_mul_B", bus.mul_B_o, 0);
    checkOutput("rst_mul_valid", bus.mul_valid_o, 0);
    checkOutput("rst_sgf", bus.sgf_result_o, 0);
    checkOutput("rst_done", bus.done_o, 0);
    checkOutput("rst_inflight", bus.inflight_o, 0);
    bus.req_i  = 2'b00;
    bus0.req_i = 2'b00;
    rst        = 1'b0;

    // Single issue: 3*5, inflight 0,1,1,1,0
    $display("[TB] single issue");
    applyStimulus(2'b01, 54'd3, 54'd5, 54'd0, 54'd0, 2'b01);
    checkOutput("single_inflight_T", bus.inflight_o, 0);
    applyStimulus(2'b00, 54'd0, 54'd0, 54'd0, 54'd0, 2'b00);
    checkOutput("single_valid", bus.mul_valid_o, 1);
    checkOutput("single_mul_A", bus.mul_A_o, 3);
    checkOutput("single_mul_B", bus.mul_B_o, 5);
    checkOutput("single_inflight_T1", bus.inflight_o, 1);
    applyStimulus(2'b00, 54'd0, 54'd0, 54'd0, 54'd0, 2'b00);
    checkOutput("single_inflight_T2", bus.inflight_o, 1);
    checkOutput("single_valid_T2", bus.mul_valid_o, 0);
    applyStimulus(2'b00, 54'd0, 54'd0, 54'd0, 54'd0, 2'b00);
    checkOutput("single_inflight_T3", bus.inflight_o, 1);
    applyStimulus(2'b00, 54'd0, 54'd0, 54'd0, 54'd0, 2'b00);
    checkOutput("single_inflight_T4", bus.inflight_o, 0);
    checkOutput("single_done_T4", bus.done_o, 2'b01);
    checkOutput("single_sgf_T4", bus.sgf_result_o, 15);

    // Idle hold: operands and product hold, nothing launches or retires
    $display("[TB] idle hold");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 54'd11, 54'd13, 54'd17, 54'd19, 2'b00);
      checkOutput("idle_valid", bus.mul_valid_o, 0);
      checkOutput("idle_mul_A", bus.mul_A_o, 3);
      checkOutput("idle_mul_B", bus.mul_B_o, 5);
      checkOutput("idle_done", bus.done_o, 0);
      checkOutput("idle_inflight", bus.inflight_o, 0);
      checkOutput("idle_sgf", bus.sgf_result_o, 15);
    end

    // Reset mid-flight: job 6*6 must never complete
    $display("[TB] reset mid-flight");
    applyStimulus(2'b01, 54'd6, 54'd6, 54'd0, 54'd0, 2'b01);
    @(negedge clk);
    rst       = 1'b1;
    bus.req_i = 2'b01;
    sb.delete();
    #1;
    checkOutput("midrst_gnt", bus.gnt_o, 2'b00);
    @(negedge clk);
    rst       = 1'b0;
    bus.req_i = 2'b00;
    checkOutput("midrst_inflight", bus.inflight_o, 0);
    checkOutput("midrst_valid", bus.mul_valid_o, 0);
    checkOutput("midrst_done", bus.done_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", bus.done_o, 0);
      checkOutput("midrst_inflight_hold", bus.inflight_o, 0);
    end

    // Contention right after reset: requester 0 wins the first tie
    $display("[TB] contention");
    applyStimulus(2'b11, 54'd2, 54'd7, 54'd4, 54'd9, 2'b01);
    applyStimulus(2'b11, 54'd2, 54'd7, 54'd4, 54'd9, 2'b10);
    applyStimulus(2'b11, 54'd2, 54'd7, 54'd4, 54'd9, 2'b01);
    applyStimulus(2'b11, 54'd2, 54'd7, 54'd4, 54'd9, 2'b10);
    checkOutput("cont_inflight", bus.inflight_o, 3);
    drain();
    checkOutput("cont_inflight_end", bus.inflight_o, 0);

    // Back-to-back from requester 1 with a wide operand
    $display("[TB] back-to-back");
    big = SW'(1) << 53;
    applyStimulus(2'b10, 54'd0, 54'd0, big, 54'd1, 2'b10);
    applyStimulus(2'b10, 54'd0, 54'd0, big, 54'd2, 2'b10);
    applyStimulus(2'b10, 54'd0, 54'd0, big, 54'd3, 2'b10);
    applyStimulus(2'b00, 54'd0, 54'd0, 54'd0, 54'd0, 2'b00);
    checkOutput("b2b_inflight_peak", bus.inflight_o, 3);
    drain();
    checkOutput("b2b_inflight_end", bus.inflight_o, 0);

    // Combinational multiplier build: done at T+2 with the full product
    $display("[TB] LAT=0 build");
    m  = {1'b0, {53{1'b1}}};
    mm = PW'(m) * PW'(m);
    @(negedge clk);
    bus0.req_i     = 2'b01;
    bus0.Data_A0_i = m;
    bus0.Data_B0_i = m;
    #1;
    checkOutput("l0_gnt", bus0.gnt_o, 2'b01);
    @(negedge clk);
    bus0.req_i = 2'b00;
    checkOutput("l0_valid", bus0.mul_valid_o, 1);
    checkOutput("l0_inflight_T1", bus0.inflight_o, 1);
    checkOutput("l0_done_T1", bus0.done_o, 0);
    @(negedge clk);
    checkOutput("l0_done_T2", bus0.done_o, 2'b01);
    checkOutput("l0_sgf_T2", bus0.sgf_result_o, mm);
    checkOutput("l0_inflight_T2", bus0.inflight_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("l0_idle_done", bus0.done_o, 0);
      checkOutput("l0_idle_sgf", bus0.sgf_result_o, mm);
    end

    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
